memoria_datos_lsu: RTL and testbench
====================================

// Module: memoria_datos_lsu
// PURPOSE
//  Data-memory responder for the RISCV32 core: executes the memory requests the control unit encodes on WEmem/Lreg.
//  Supported operations: sw, sb, lw, lbu.
//  Sits between the execute stage (address = ALU result, wdata = rs2) and the write-back mux (rdata -> ALUreg mux).
//  Owns a word-organised synchronous RAM with byte-lane writes, a load formatter and a 3-state read FSM.
// PARAMETERS
//  DEPTH_WORDS  256  RAM depth in 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
//  AW           8    word-index width = clog2(DEPTH_WORDS)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   request present this cycle
//  req_ready    out  1   responder can accept a request
//  WEmem        in   2   00 none, 01 sb (byte), 10 sw (word), 11 reserved
//  load         in   1   1 = load request (lw/lbu)
//  Lreg         in   1   load size: 0 = lw (word), 1 = lbu (byte, zero-extended)
//  addr         in   32  byte address
//  wdata        in   32  store data; sb uses wdata[7:0]
//  rdata        out  32  formatted load data
//  rdata_valid  out  1   one-cycle pulse, rdata valid
//  err          out  1   one-cycle pulse, request rejected (see rules)
// BEHAVIOUR
//  Reset: req_ready=1, rdata=0, rdata_valid=0, err=0, FSM=IDLE, latched request cleared; RAM contents are not reset.
//  Accept condition: req_valid & req_ready on a rising edge.
//  Error checks at accept, evaluated in this order:
//   - load=1 with WEmem!=00 -> err
//   - WEmem=11 -> err
//   - addr >= 4*DEPTH_WORDS -> err
//   - sw or lw with addr[1:0]!=0 -> err
//  On err: pulse err the next cycle; no RAM write; no rdata_valid; FSM stays IDLE.
//  Request with load=0 and WEmem=00: no-op, no pulses.
//  Store (sw/sb) completes at the accept edge:
//   - sw writes all 4 lanes of word addr[AW+1:2]
//   - sb writes lane addr[1:0] only (lane0 = bits 7:0, little-endian); the other 3 lanes are unchanged
//   - req_ready stays 1, so back-to-back stores are accepted every cycle
//  Load FSM: IDLE -> RD -> FMT -> IDLE.
//   - IDLE: on an accepted valid load, latch Lreg and addr[1:0], issue the RAM read, go to RD, req_ready<=0
//   - RD: RAM output available; go to FMT
//   - FMT: rdata <= lw ? word : {24'h0, selected byte}; rdata_valid<=1 for exactly one cycle; req_ready<=1; go to IDLE
//   - Latency: load accepted at edge N -> rdata_valid high in the cycle after edge N+2
//   - Next request can be accepted at edge N+3
//  rdata holds its last value until the next load completes; it does not change on stores or errors.
//  Store at edge N followed by a load of the same word at edge N+1 returns the new data (write-first; no forwarding).
//  req_valid while req_ready=0: ignored; the requester must hold the request.
//  rst_n low mid-load (RD/FMT): FSM->IDLE immediately, pending read dropped, no rdata_valid after reset release.
//  Width rules: the word index uses addr[AW+1:2]; the upper address bits are checked only by the range test.
// TESTING
//  1 reset: rst_n=0 -> req_ready=1, rdata=0, rdata_valid=0, err=0; release, idle 5 cycles -> no pulses.
//  2 sw addr=0x10 wdata=0xDEADBEEF, then lw addr=0x10
//    -> rdata=0xDEADBEEF, rdata_valid 3 cycles after accept, req_ready low for 2 cycles.
//  3 sb addr=0x11 wdata=0x000000A5, then lw addr=0x10 -> rdata=0xDEADA5EF.
//    lbu addr=0x11 -> rdata=0x000000A5. lbu addr=0x13 -> 0x000000DE.
//  4 errors, each -> err pulse, no write, no rdata_valid, RAM[0x10] unchanged:
//    sw addr=0x12; lw addr=0x401 (DEPTH 256); WEmem=11; load=1 with WEmem=10.
//  5 back-to-back sb to 0x20,0x21,0x22,0x23 (data 11,22,33,44) on 4 consecutive cycles
//    -> lw 0x20 = 0x44332211; req_valid held during a load busy window -> accepted only at edge N+3.
//  6 lw accepted, rst_n pulsed low during RD -> no rdata_valid, req_ready=1 after release.
//    A following lw returns correct data.

Source files
------------

// File: rtl/memoria_datos_lsu.sv
// Data-memory responder: word-organised synchronous RAM with byte-lane stores,
// a three-state read FSM and a load formatter for sw/sb/lw/lbu.
module memoria_datos_lsu #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  WEmem,
    input  logic        load,
    input  logic        Lreg,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StRd, StFmt} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd_word_q;
    logic          lreg_q;
    logic [1:0]    lane_q;
    logic [AW-1:0] word_idx;
    logic          accept;
    logic          req_err;
    logic          do_store;
    logic          do_load;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data;
    logic [7:0]    sel_byte;
    logic [31:0]   rdata_d;
    logic          rdata_valid_d;
    logic          err_d;

    assign word_idx  = addr[AW+1:2];
    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid & req_ready;

    // Any of these rejects the request; the order only matters for documentation.
    always_comb begin
        req_err = 1'b0;
        if (load && (WEmem != 2'b00)) begin
            req_err = 1'b1;
        end else if (WEmem == 2'b11) begin
            req_err = 1'b1;
        end else if (addr >= ADDR_LIMIT) begin
            req_err = 1'b1;
        end else if (((WEmem == 2'b10) || (load && !Lreg)) && (addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
    end

    assign do_store = accept & ~req_err & ~load & (WEmem != 2'b00);
    assign do_load  = accept & ~req_err & load;

    always_comb begin
        byte_en = 4'b0000;
        wr_data = wdata;
        if (do_store) begin
            if (WEmem == 2'b10) begin
                byte_en = 4'b1111;
            end else begin
                byte_en = 4'b0001 << addr[1:0];
                wr_data = {4{wdata[7:0]}};
            end
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (do_load) begin
            rd_word_q <= mem[word_idx];
        end
    end

    assign sel_byte = rd_word_q[{lane_q, 3'b000} +: 8];

    always_comb begin
        state_d       = state_q;
        rdata_d       = rdata;
        rdata_valid_d = 1'b0;
        err_d         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        err_d = 1'b1;
                    end else if (load) begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                state_d = StFmt;
            end
            StFmt: begin
                rdata_d       = lreg_q ? {24'h0, sel_byte} : rd_word_q;
                rdata_valid_d = 1'b1;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            lreg_q      <= 1'b0;
            lane_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            rdata       <= rdata_d;
            rdata_valid <= rdata_valid_d;
            err         <= err_d;
            if (do_load) begin
                lreg_q <= Lreg;
                lane_q <= addr[1:0];
            end
        end
    end

endmodule

// File: tb/tb_memoria_datos_lsu.sv
// Directed bench for memoria_datos_lsu: stores, loads, lane formatting, rejects,
// busy-window handshake and mid-load reset, each scenario checked inline.
module tb_memoria_datos_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  WEmem;
    logic        load;
    logic        Lreg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;

    int vecs;
    int miscompares;

    memoria_datos_lsu #(
        .DEPTH_WORDS(256),
        .AW(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .WEmem(WEmem),
        .load(load),
        .Lreg(Lreg),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .rdata_valid(rdata_valid),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic v, input logic [1:0] we, input logic ld, input logic lr,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        WEmem     = we;
        load      = ld;
        Lreg      = lr;
        addr      = a;
        wdata     = d;
    endtask

    // Issue one request and observe five cycles after the accept edge.
    task automatic run_req(input logic [1:0] we, input logic ld, input logic lr,
                           input logic [31:0] a, input logic [31:0] d,
                           output int n_valid, output int lat, output int n_err,
                           output int busy, output logic [31:0] got);
        apply(1'b1, we, ld, lr, a, d);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_valid = 0; lat = 0; n_err = 0; busy = 0; got = rdata;
        for (int i = 1; i <= 5; i++) begin
            if (rdata_valid) begin
                n_valid++;
                if (lat == 0) lat = i;
                got = rdata;
            end
            if (err) n_err++;
            if (!req_ready) busy++;
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset;
        int pulses;
        rst_n = 1'b0;
        apply(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        vecs++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        vecs++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        vecs++; if (rdata_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid got=%b exp=0", rdata_valid); end
        vecs++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b exp=0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rdata_valid || err || !req_ready) pulses++;
        end
        vecs++; if (pulses !== 0) begin miscompares++; $display("FAIL rst_idle got=%0d exp=0", pulses); end
    endtask

    task automatic test_store_load;
        int nv, lat, ne, busy;
        logic [31:0] got;
        run_req(2'b10, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, nv, lat, ne, busy, got);
        vecs++; if (ne !== 0 || nv !== 0) begin miscompares++; $display("FAIL sw_pulses got err=%0d valid=%0d exp 0/0", ne, nv); end
        vecs++; if (busy !== 0) begin miscompares++; $display("FAIL sw_ready got busy=%0d exp=0", busy); end
        run_req(2'b00, 1'b1, 1'b0, 32'h10, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (got !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_data got=%h exp=deadbeef", got); end
        vecs++; if (lat !== 3) begin miscompares++; $display("FAIL lw_latency got=%0d exp=3", lat); end
        vecs++; if (nv !== 1) begin miscompares++; $display("FAIL lw_pulse got=%0d exp=1", nv); end
        vecs++; if (busy !== 2) begin miscompares++; $display("FAIL lw_busy got=%0d exp=2", busy); end
    endtask

    task automatic test_byte;
        int nv, lat, ne, busy;
        logic [31:0] got;
        run_req(2'b01, 1'b0, 1'b0, 32'h11, 32'hFFFFFFA5, nv, lat, ne, busy, got);
        vecs++; if (ne !== 0) begin miscompares++; $display("FAIL sb_err got=%0d exp=0", ne); end
        run_req(2'b00, 1'b1, 1'b0, 32'h10, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (got !== 32'hDEADA5EF) begin miscompares++; $display("FAIL sb_lw got=%h exp=deada5ef", got); end
        run_req(2'b00, 1'b1, 1'b1, 32'h11, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (got !== 32'h000000A5) begin miscompares++; $display("FAIL lbu_11 got=%h exp=000000a5", got); end
        run_req(2'b00, 1'b1, 1'b1, 32'h10, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (got !== 32'h000000EF) begin miscompares++; $display("FAIL lbu_10 got=%h exp=000000ef", got); end
        run_req(2'b00, 1'b1, 1'b1, 32'h13, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (got !== 32'h000000DE) begin miscompares++; $display("FAIL lbu_13 got=%h exp=000000de", got); end
        vecs++; if (lat !== 3) begin miscompares++; $display("FAIL lbu_latency got=%0d exp=3", lat); end
        run_req(2'b00, 1'b0, 1'b0, 32'h10, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (ne !== 0 || nv !== 0) begin miscompares++; $display("FAIL noop got err=%0d valid=%0d exp 0/0", ne, nv); end
    endtask

    task automatic test_errors;
        int nv, lat, ne, busy;
        logic [31:0] got;
        logic [1:0]  t_we [5];
        logic        t_ld [5];
        logic        t_lr [5];
        logic [31:0] t_a  [5];
        t_we = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b10};
        t_ld = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        t_lr = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
        t_a  = '{32'h12, 32'h401, 32'h10, 32'h10, 32'h410};
        for (int i = 0; i < 5; i++) begin
            run_req(t_we[i], t_ld[i], t_lr[i], t_a[i], 32'h12345678, nv, lat, ne, busy, got);
            vecs++; if (ne !== 1 || nv !== 0) begin miscompares++; $display("FAIL err_case%0d got err=%0d valid=%0d exp 1/0", i, ne, nv); end
            vecs++; if (rdata !== 32'h000000DE) begin miscompares++; $display("FAIL err_hold%0d got=%h exp=000000de", i, rdata); end
        end
        run_req(2'b00, 1'b1, 1'b0, 32'h10, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (got !== 32'hDEADA5EF) begin miscompares++; $display("FAIL err_nowrite got=%h exp=deada5ef", got); end
        run_req(2'b01, 1'b0, 1'b0, 32'h3FF, 32'h0000005A, nv, lat, ne, busy, got);
        vecs++; if (ne !== 0) begin miscompares++; $display("FAIL sb_top_err got=%0d exp=0", ne); end
        run_req(2'b00, 1'b1, 1'b1, 32'h3FF, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (got !== 32'h0000005A || nv !== 1) begin miscompares++; $display("FAIL lbu_top got=%h/%0d exp=0000005a/1", got, nv); end
        run_req(2'b00, 1'b1, 1'b1, 32'h400, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (ne !== 1 || nv !== 0) begin miscompares++; $display("FAIL lbu_range got err=%0d valid=%0d exp 1/0", ne, nv); end
    endtask

    task automatic test_back_to_back;
        int nv, lat, ne, busy;
        logic [31:0] got;
        logic [7:0]  bt [4];
        int          stalls;
        bt = '{8'h11, 8'h22, 8'h33, 8'h44};
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 2'b01, 1'b0, 1'b0, 32'h20 + 32'(i), {24'h0, bt[i]});
            @(posedge clk); #1;
            if (!req_ready || err) stalls++;
        end
        req_valid = 1'b0;
        vecs++; if (stalls !== 0) begin miscompares++; $display("FAIL b2b_stall got=%0d exp=0", stalls); end
        run_req(2'b00, 1'b1, 1'b0, 32'h20, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (got !== 32'h44332211) begin miscompares++; $display("FAIL b2b_lw got=%h exp=44332211", got); end

        // Second load held on the bus during the first load's busy window.
        apply(1'b1, 2'b00, 1'b1, 1'b0, 32'h20, 32'h0);
        @(posedge clk); #1;
        apply(1'b1, 2'b00, 1'b1, 1'b1, 32'h22, 32'h0);
        @(posedge clk); #1;
        vecs++; if (rdata_valid !== 1'b0 || req_ready !== 1'b0) begin miscompares++; $display("FAIL hold_n1 got valid=%b ready=%b exp 0/0", rdata_valid, req_ready); end
        @(posedge clk); #1;
        vecs++; if (rdata_valid !== 1'b1 || rdata !== 32'h44332211 || req_ready !== 1'b1) begin miscompares++; $display("FAIL hold_n2 got valid=%b data=%h ready=%b exp 1/44332211/1", rdata_valid, rdata, req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        vecs++; if (req_ready !== 1'b0 || rdata_valid !== 1'b0) begin miscompares++; $display("FAIL hold_n3 got ready=%b valid=%b exp 0/0", req_ready, rdata_valid); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        vecs++; if (rdata_valid !== 1'b1 || rdata !== 32'h00000033) begin miscompares++; $display("FAIL hold_lbu got valid=%b data=%h exp 1/00000033", rdata_valid, rdata); end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midload;
        int nv, lat, ne, busy;
        logic [31:0] got;
        int pulses;
        apply(1'b1, 2'b00, 1'b1, 1'b0, 32'h20, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        vecs++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rdata_valid) pulses++;
        end
        vecs++; if (pulses !== 0) begin miscompares++; $display("FAIL midrst_valid got=%0d exp=0", pulses); end
        run_req(2'b00, 1'b1, 1'b0, 32'h20, 32'h0, nv, lat, ne, busy, got);
        vecs++; if (got !== 32'h44332211 || lat !== 3) begin miscompares++; $display("FAIL midrst_lw got=%h lat=%0d exp 44332211/3", got, lat); end
    endtask

    initial begin
        vecs = 0;
        miscompares = 0;
        test_reset();
        test_store_load();
        test_byte();
        test_errors();
        test_back_to_back();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
